// File: rtl/deconv_pkg.sv
// rtl/deconv_pkg.sv - shared constants, state encoding and geometry helper for the deconv result writer
package deconv_pkg;

  localparam int N_CORES = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Output pixels per column once overlapping kernel footprints are merged.
  function automatic int calc_n_pix_out(input int size_of_feature,
                                        input int size_of_weight,
                                        input int stride);
    return size_of_feature * size_of_weight
         - (size_of_weight - stride) * (size_of_feature - 1);
  endfunction

endpackage

// File: rtl/deconv_col_slot_fifo.sv
// rtl/deconv_col_slot_fifo.sv - two-entry column-wide FIFO; push while full is accepted when a pop happens in the same cycle
module deconv_col_slot_fifo #(
  parameter int WIDTH = 128
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = i_pop && (count != 2'd0);
  assign do_push = i_push && ((count != 2'd2) || do_pop);

  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem[wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (i_flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign o_head  = mem[rd_ptr];
  assign o_full  = (count == 2'd2);
  assign o_empty = (count == 2'd0);

endmodule

// File: rtl/deconv_result_writer.sv
// rtl/deconv_result_writer.sv - buffers per-core deconvolution columns and drains them round-robin into a BRAM, one pixel per cycle
module deconv_result_writer
  import deconv_pkg::*;
#(
  parameter int PIX_WIDTH       = 16,
  parameter int SIZE_OF_FEATURE = 2,
  parameter int SIZE_OF_WEIGHT  = 3,
  parameter int STRIDE          = 1,
  parameter int BRAM_DATA_WIDTH = 32,
  parameter int ADDRESS_WIDTH   = 13,
  localparam int N_PIX_OUT      = calc_n_pix_out(SIZE_OF_FEATURE, SIZE_OF_WEIGHT, STRIDE)
) (
  input  logic                                      i_clk,
  input  logic                                      i_rst_n,
  input  logic [3:0]                                i_deconv_valid,
  input  logic [N_PIX_OUT*2*PIX_WIDTH*N_CORES-1:0]  i_deconv_col_result,
  input  logic                                      i_start,
  input  logic [ADDRESS_WIDTH-1:0]                  i_base_addr,
  input  logic [ADDRESS_WIDTH-1:0]                  i_region_stride,
  input  logic [15:0]                               i_cols_per_core,
  output logic                                      o_bram_en,
  output logic [BRAM_DATA_WIDTH/8-1:0]              o_bram_we,
  output logic [ADDRESS_WIDTH-1:0]                  o_bram_addr,
  output logic [BRAM_DATA_WIDTH-1:0]                o_bram_din,
  output logic                                      o_busy,
  output logic                                      o_done,
  output logic                                      o_overflow
);

  localparam int PW2   = 2 * PIX_WIDTH;
  localparam int COL_W = PW2 * N_PIX_OUT;
  localparam int PCW   = (N_PIX_OUT > 1) ? $clog2(N_PIX_OUT) : 1;
  localparam logic [PCW-1:0] LAST_PIX = PCW'(N_PIX_OUT - 1);

  if (BRAM_DATA_WIDTH != 2 * PIX_WIDTH) begin : g_width_check
    $error("deconv_result_writer: BRAM_DATA_WIDTH must equal 2*PIX_WIDTH");
  end

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] base_q;
  logic [ADDRESS_WIDTH-1:0] stride_q;
  logic [15:0]              cols_q;
  logic [15:0]              acc_cnt [N_CORES];
  logic [15:0]              col_idx [N_CORES];
  logic [1:0]               rr_ptr;
  logic                     active;
  logic [1:0]               cur_core;
  logic [PCW-1:0]           pix_cnt;
  logic                     overflow_q;

  logic [N_CORES-1:0]       fifo_push;
  logic [N_CORES-1:0]       fifo_pop;
  logic [N_CORES-1:0]       fifo_full;
  logic [N_CORES-1:0]       fifo_empty;
  logic [COL_W-1:0]         fifo_head [N_CORES];
  logic                     fifo_flush;
  logic [N_CORES-1:0]       core_complete;
  logic [N_CORES-1:0]       core_take;
  logic [N_CORES-1:0]       core_drop;
  logic [N_CORES-1:0]       core_written;
  logic                     all_done;

  logic                     arb_found;
  logic [1:0]               arb_sel;
  logic [1:0]               cand;
  logic                     write_en;
  logic [1:0]               write_core;
  logic [PCW-1:0]           write_pix;
  logic                     write_last;
  logic [COL_W-1:0]         head_sel;
  logic [PW2-1:0]           pixel;
  logic [ADDRESS_WIDTH-1:0] core_off;
  logic [ADDRESS_WIDTH-1:0] col_off;
  logic [ADDRESS_WIDTH-1:0] addr_calc;

  assign fifo_flush = (state == ST_IDLE) && i_start;

  for (genvar k = 0; k < N_CORES; k++) begin : g_core
    // A core that already has its quota accepted ignores further columns without flagging overflow.
    assign core_complete[k] = (acc_cnt[k] >= cols_q);
    assign core_take[k]     = (state == ST_RUN) && i_deconv_valid[k] && !core_complete[k];
    assign fifo_pop[k]      = write_en && write_last && (write_core == 2'(k));
    assign fifo_push[k]     = core_take[k] && (!fifo_full[k] || fifo_pop[k]);
    assign core_drop[k]     = core_take[k] && fifo_full[k] && !fifo_pop[k];
    assign core_written[k]  = (col_idx[k] >= cols_q);

    deconv_col_slot_fifo #(
      .WIDTH (COL_W)
    ) u_fifo (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_flush     (fifo_flush),
      .i_push      (fifo_push[k]),
      .i_push_data (i_deconv_col_result[k*COL_W +: COL_W]),
      .i_pop       (fifo_pop[k]),
      .o_head      (fifo_head[k]),
      .o_full      (fifo_full[k]),
      .o_empty     (fifo_empty[k])
    );
  end

  assign all_done = &core_written;

  always_comb begin
    arb_found = 1'b0;
    arb_sel   = rr_ptr;
    cand      = rr_ptr;
    for (int i = 0; i < N_CORES; i++) begin
      cand = rr_ptr + 2'(i);
      if (!arb_found && !fifo_empty[cand]) begin
        arb_found = 1'b1;
        arb_sel   = cand;
      end
    end
  end

  // An idle drain engine starts pixel 0 of the arbitrated column in the same cycle, so columns go back to back.
  assign write_en   = (state == ST_RUN) && (active || arb_found);
  assign write_core = active ? cur_core : arb_sel;
  assign write_pix  = active ? pix_cnt : '0;
  assign write_last = (write_pix == LAST_PIX);
  assign head_sel   = fifo_head[write_core];
  assign pixel      = head_sel[write_pix*PW2 +: PW2];

  always_comb begin
    core_off  = stride_q * ADDRESS_WIDTH'(write_core);
    col_off   = ADDRESS_WIDTH'(col_idx[write_core]) * ADDRESS_WIDTH'(N_PIX_OUT);
    addr_calc = base_q + core_off + col_off + ADDRESS_WIDTH'(write_pix);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      base_q     <= '0;
      stride_q   <= '0;
      cols_q     <= '0;
      rr_ptr     <= 2'd0;
      active     <= 1'b0;
      cur_core   <= 2'd0;
      pix_cnt    <= '0;
      overflow_q <= 1'b0;
      for (int k = 0; k < N_CORES; k++) begin
        acc_cnt[k] <= '0;
        col_idx[k] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            state      <= ST_RUN;
            base_q     <= i_base_addr;
            stride_q   <= i_region_stride;
            cols_q     <= i_cols_per_core;
            rr_ptr     <= 2'd0;
            active     <= 1'b0;
            pix_cnt    <= '0;
            overflow_q <= 1'b0;
            for (int k = 0; k < N_CORES; k++) begin
              acc_cnt[k] <= '0;
              col_idx[k] <= '0;
            end
          end
        end
        ST_RUN: begin
          if (all_done) begin
            state <= ST_DONE;
          end
          if (|core_drop) begin
            overflow_q <= 1'b1;
          end
          for (int k = 0; k < N_CORES; k++) begin
            if (fifo_push[k]) begin
              acc_cnt[k] <= acc_cnt[k] + 16'd1;
            end
          end
          if (write_en) begin
            if (write_last) begin
              active              <= 1'b0;
              pix_cnt             <= '0;
              col_idx[write_core] <= col_idx[write_core] + 16'd1;
              rr_ptr              <= write_core + 2'd1;
            end else begin
              active   <= 1'b1;
              cur_core <= write_core;
              pix_cnt  <= write_pix + PCW'(1);
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_bram_en   = write_en;
  assign o_bram_we   = {(BRAM_DATA_WIDTH/8){write_en}};
  assign o_bram_addr = write_en ? addr_calc : '0;
  assign o_bram_din  = write_en ? BRAM_DATA_WIDTH'(pixel) : '0;
  assign o_busy      = (state != ST_IDLE);
  assign o_done      = (state == ST_DONE);
  assign o_overflow  = overflow_q;

endmodule

// File: tb/tb_deconv_result_writer.sv
// tb/tb_deconv_result_writer.sv - directed self-checking bench for deconv_result_writer
module tb_deconv_result_writer;

  localparam int N_PIX = 4;
  localparam int COL_W = 128;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [3:0]         i_valid = '0;
  logic [4*COL_W-1:0] col_bus = '0;
  logic               i_start = 1'b0;
  logic [12:0]        i_base = '0;
  logic [12:0]        i_stride = '0;
  logic [15:0]        i_cols = '0;
  logic               o_bram_en;
  logic [3:0]         o_bram_we;
  logic [12:0]        o_bram_addr;
  logic [31:0]        o_bram_din;
  logic               o_busy;
  logic               o_done;
  logic               o_overflow;

  always #5 clk = ~clk;

  deconv_result_writer dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .i_deconv_valid      (i_valid),
    .i_deconv_col_result (col_bus),
    .i_start             (i_start),
    .i_base_addr         (i_base),
    .i_region_stride     (i_stride),
    .i_cols_per_core     (i_cols),
    .o_bram_en           (o_bram_en),
    .o_bram_we           (o_bram_we),
    .o_bram_addr         (o_bram_addr),
    .o_bram_din          (o_bram_din),
    .o_busy              (o_busy),
    .o_done              (o_done),
    .o_overflow          (o_overflow)
  );

  typedef struct {
    logic [12:0] addr;
    logic [31:0] din;
    logic [3:0]  we;
  } wr_t;

  wr_t wq[$];

  always @(negedge clk) begin
    if (o_bram_en) wq.push_back('{o_bram_addr, o_bram_din, o_bram_we});
  end

  typedef struct packed {
    logic [12:0]      base;
    logic [12:0]      stride;
    logic [31:0]      seed;
    logic [3:0][12:0] exp_addr;
  } vec_t;

  vec_t vecs [4];

  int          checks = 0;
  int          errors = 0;
  int          dones;
  logic [12:0] ea;
  logic [31:0] ed;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [COL_W-1:0] make_col(input int core, input logic [31:0] seed);
    logic [COL_W-1:0] c;
    c = '0;
    for (int p = 0; p < N_PIX; p++) c[p*32 +: 32] = seed + 32'(core*4 + p);
    return c;
  endfunction

  task automatic start(input logic [12:0] base, input logic [12:0] stride, input logic [15:0] cols);
    i_base   = base;
    i_stride = stride;
    i_cols   = cols;
    i_start  = 1'b1;
    @(posedge clk); #1;
    i_start  = 1'b0;
  endtask

  task automatic push(input logic [3:0] mask, input logic [31:0] seed);
    for (int k = 0; k < 4; k++) col_bus[k*COL_W +: COL_W] = make_col(k, seed);
    i_valid = mask;
    @(posedge clk); #1;
    i_valid = '0;
  endtask

  task automatic wait_idle(input int max, output int n_done);
    n_done = 0;
    for (int c = 0; c < max; c++) begin
      @(posedge clk); #1;
      if (o_done) n_done++;
      if (!o_busy) break;
    end
    check("wait_idle_busy", 64'(o_busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{13'h0100, 13'h0040, 32'h0000_1000, {13'h01C0, 13'h0180, 13'h0140, 13'h0100}};
    vecs[1] = '{13'h0000, 13'h0004, 32'h0000_2000, {13'h000C, 13'h0008, 13'h0004, 13'h0000}};
    vecs[2] = '{13'h1FFE, 13'h0010, 32'hABCD_0000, {13'h002E, 13'h001E, 13'h000E, 13'h1FFE}};
    vecs[3] = '{13'h0A00, 13'h1F00, 32'h8000_0010, {13'h0700, 13'h0800, 13'h0900, 13'h0A00}};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_en", 64'(o_bram_en), 64'd0);
    check("rst_we", 64'(o_bram_we), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_done", 64'(o_done), 64'd0);
    check("rst_ovf", 64'(o_overflow), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single column on core 0, written the cycle after it is captured
    wq.delete();
    start(13'h100, 13'h040, 16'd1);
    push(4'b0001, 32'd1);
    check("single_first_en", 64'(o_bram_en), 64'd1);
    check("single_first_addr", 64'(o_bram_addr), 64'h100);
    repeat (4) @(posedge clk);
    #1;
    check("single_count", 64'(wq.size()), 64'd4);
    for (int p = 0; p < 4 && p < wq.size(); p++) begin
      check($sformatf("single_addr%0d", p), 64'(wq[p].addr), 64'(13'h100 + 13'(p)));
      check($sformatf("single_din%0d", p), 64'(wq[p].din), 64'(32'd1 + 32'(p)));
    end
    check("single_idle_en", 64'(o_bram_en), 64'd0);
    check("single_still_busy", 64'(o_busy), 64'd1);
    push(4'b1110, 32'd1);
    wait_idle(60, dones);
    check("single_done_pulses", 64'(dones), 64'd1);
    check("single_total", 64'(wq.size()), 64'd16);

    // all-core bursts from the vector table
    for (int v = 0; v < 4; v++) begin
      wq.delete();
      start(vecs[v].base, vecs[v].stride, 16'd1);
      push(4'hF, vecs[v].seed);
      wait_idle(60, dones);
      check($sformatf("vec%0d_done", v), 64'(dones), 64'd1);
      check($sformatf("vec%0d_count", v), 64'(wq.size()), 64'd16);
      for (int i = 0; i < 16 && i < wq.size(); i++) begin
        ea = vecs[v].exp_addr[i/4] + 13'(i % 4);
        ed = vecs[v].seed + 32'(i);
        check($sformatf("vec%0d_addr%0d", v, i), 64'(wq[i].addr), 64'(ea));
        check($sformatf("vec%0d_din%0d", v, i), 64'(wq[i].din), 64'(ed));
        check($sformatf("vec%0d_we%0d", v, i), 64'(wq[i].we), 64'hF);
      end
    end

    // zero count completes without writes
    wq.delete();
    start(13'h0, 13'h0, 16'd0);
    check("zero_busy_c1", 64'(o_busy), 64'd1);
    check("zero_done_c1", 64'(o_done), 64'd0);
    @(posedge clk); #1;
    check("zero_done_c2", 64'(o_done), 64'd1);
    @(posedge clk); #1;
    check("zero_done_c3", 64'(o_done), 64'd0);
    check("zero_busy_c3", 64'(o_busy), 64'd0);
    check("zero_writes", 64'(wq.size()), 64'd0);

    // overflow: third core1 column while core0 drains is dropped
    wq.delete();
    start(13'h0, 13'h100, 16'd3);
    push(4'b0011, 32'h20);
    push(4'b0010, 32'h30);
    check("ovf_before_drop", 64'(o_overflow), 64'd0);
    push(4'b0010, 32'hD0);
    check("ovf_set", 64'(o_overflow), 64'd1);
    repeat (20) @(posedge clk);
    #1;
    check("ovf_count", 64'(wq.size()), 64'd12);
    for (int i = 0; i < 12 && i < wq.size(); i++) begin
      if (i < 4) begin
        ea = 13'(i);
        ed = 32'h20 + 32'(i);
      end else if (i < 8) begin
        ea = 13'h100 + 13'(i - 4);
        ed = 32'h24 + 32'(i - 4);
      end else begin
        ea = 13'h100 + 13'(i - 4);
        ed = 32'h34 + 32'(i - 8);
      end
      check($sformatf("ovf_addr%0d", i), 64'(wq[i].addr), 64'(ea));
      check($sformatf("ovf_din%0d", i), 64'(wq[i].din), 64'(ed));
    end
    check("ovf_sticky", 64'(o_overflow), 64'd1);
    check("ovf_not_done", 64'(o_busy), 64'd1);
    start(13'h0, 13'h0, 16'd0);
    @(posedge clk); #1;
    check("start_ignored_busy", 64'(o_busy), 64'd1);
    check("start_ignored_ovf", 64'(o_overflow), 64'd1);

    // reset in the middle of a drain
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wq.delete();
    start(13'h0, 13'h040, 16'd1);
    push(4'b0001, 32'h50);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_en", 64'(o_bram_en), 64'd0);
    check("mid_rst_we", 64'(o_bram_we), 64'd0);
    check("mid_rst_busy", 64'(o_busy), 64'd0);
    check("mid_rst_ovf", 64'(o_overflow), 64'd0);
    check("mid_rst_writes", 64'(wq.size()), 64'd2);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    push(4'hF, 32'h60);
    push(4'hF, 32'h70);
    push(4'hF, 32'h80);
    repeat (6) @(posedge clk);
    #1;
    check("post_rst_no_writes", 64'(wq.size()), 64'd2);
    check("post_rst_idle", 64'(o_busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
